// File: rtl/load_return_unit_pkg.sv
// Shared op codes, address map and hold-FSM states for the load return path.
// Optional feature macro LRU_DEV_SUBWORD_EN is consumed by load_return_unit.
package load_return_unit_pkg;

    localparam logic [31:0] DM_TOP    = 32'h0000_3000;
    localparam logic [31:0] TMR0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TMR1_BASE = 32'h0000_7F10;
    localparam logic [31:0] TMR_SPAN  = 32'd12;

    // Store codes live alongside the loads so the store filter shares this table.
    localparam logic [3:0] DM_NONE = 4'd0;
    localparam logic [3:0] DM_SW   = 4'd1;
    localparam logic [3:0] DM_SH   = 4'd2;
    localparam logic [3:0] DM_SB   = 4'd3;
    localparam logic [3:0] DM_LW   = 4'd4;
    localparam logic [3:0] DM_LH   = 4'd5;
    localparam logic [3:0] DM_LHU  = 4'd6;
    localparam logic [3:0] DM_LB   = 4'd7;
    localparam logic [3:0] DM_LBU  = 4'd8;

    typedef enum logic [1:0] {
        LRU_IDLE  = 2'd0,
        LRU_FRESH = 2'd1,
        LRU_HELD  = 2'd2
    } lru_state_e;

    function automatic logic is_load(input logic [3:0] ctrl);
        return (ctrl == DM_LW) || (ctrl == DM_LH) || (ctrl == DM_LHU) ||
               (ctrl == DM_LB) || (ctrl == DM_LBU);
    endfunction

    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base) && (addr < base + TMR_SPAN);
    endfunction

endpackage

// File: rtl/load_return_unit_if.sv
// M-stage request, memory read data and W-stage result of the load return unit.
// slave = the unit itself, master = pipeline/memory side driving it.
interface load_return_unit_if;
    logic [31:0] iAddr;
    logic [3:0]  ictrl;
    logic        iValid;
    logic        INT;
    logic        iStall;
    logic        iFlush;
    logic [31:0] iDM_RD;
    logic [31:0] iDEV_RD;
    logic        oEXC;
    logic        oDM_RE;
    logic        oDEV_RE;
    logic        oValid;
    logic [31:0] oRData;

    modport slave (
        input  iAddr, ictrl, iValid, INT, iStall, iFlush, iDM_RD, iDEV_RD,
        output oEXC, oDM_RE, oDEV_RE, oValid, oRData
    );

    modport master (
        output iAddr, ictrl, iValid, INT, iStall, iFlush, iDM_RD, iDEV_RD,
        input  oEXC, oDM_RE, oDEV_RE, oValid, oRData
    );
endinterface

// File: rtl/load_return_unit_extender.sv
// load_extender: lane select plus sign/zero extension of a returned word.
// Purely combinational; non-load codes pass the word through.
module load_extender
    import load_return_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [3:0]  i_ctrl,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        o_data = i_word;
        case (i_ctrl)
            DM_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            DM_LBU:  o_data = {24'd0, w_byte};
            DM_LH:   o_data = {{16{w_half[15]}}, w_half};
            DM_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end
endmodule

// File: rtl/load_return_unit.sv
// Load path: M-stage decode/AdEL/read enables, W-stage register, DM word hold across stalls.
// Latency 1 cycle plus stalls; LRU_DEV_SUBWORD_EN allows byte/half reads from timer regions.
module load_return_unit
    import load_return_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    load_return_unit_if.slave bus
);
    logic        w_ld, w_dm, w_tmr, w_lw, w_half, w_misalign, w_tmr_bad;
    logic        w_exc, w_dm_re, w_dev_re;
    logic        r_wv, r_wsrc;
    logic [3:0]  r_wctrl;
    logic [1:0]  r_wlane;
    logic [31:0] r_wdev, r_hreg, w_word, w_ext;
    logic        w_hold_load;
    lru_state_e  r_state, w_state_nxt;

    always_comb begin
        w_ld       = bus.iValid & is_load(bus.ictrl) & ~bus.INT;
        w_dm       = bus.iAddr < DM_TOP;
        w_tmr      = in_window(bus.iAddr, TMR0_BASE) | in_window(bus.iAddr, TMR1_BASE);
        w_lw       = bus.ictrl == DM_LW;
        w_half     = (bus.ictrl == DM_LH) | (bus.ictrl == DM_LHU);
        w_misalign = (w_lw & (bus.iAddr[1:0] != 2'd0)) | (w_half & bus.iAddr[0]);
`ifdef LRU_DEV_SUBWORD_EN
        w_tmr_bad  = 1'b0;
`else
        w_tmr_bad  = w_tmr & ~w_lw;
`endif
        w_exc      = w_ld & (~(w_dm | w_tmr) | w_misalign | w_tmr_bad);
        w_dm_re    = w_ld & ~w_exc & w_dm;
        w_dev_re   = w_ld & ~w_exc & w_tmr;
    end

    assign bus.oEXC    = w_exc;
    assign bus.oDM_RE  = w_dm_re;
    assign bus.oDEV_RE = w_dev_re;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wv    <= 1'b0;
            r_wsrc  <= 1'b0;
            r_wctrl <= 4'd0;
            r_wlane <= 2'd0;
            r_wdev  <= 32'd0;
        end else if (bus.iFlush) begin
            r_wv <= 1'b0;
        end else if (!bus.iStall) begin
            r_wv    <= w_dm_re | w_dev_re;
            r_wsrc  <= w_dev_re;
            r_wctrl <= bus.ictrl;
            r_wlane <= bus.iAddr[1:0];
            r_wdev  <= bus.iDEV_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LRU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DM data exists only in the first W cycle; a stall then must snapshot it.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_load = 1'b0;
        if (bus.iFlush) begin
            w_state_nxt = LRU_IDLE;
        end else if (bus.iStall) begin
            if (r_state == LRU_FRESH) begin
                w_state_nxt = LRU_HELD;
                w_hold_load = 1'b1;
            end
        end else begin
            w_state_nxt = w_dm_re ? LRU_FRESH : LRU_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hreg <= 32'd0;
        end else if (w_hold_load) begin
            r_hreg <= bus.iDM_RD;
        end else if (bus.iFlush) begin
            r_hreg <= 32'd0;
        end
    end

    always_comb begin
        w_word = bus.iDM_RD;
        if (r_wsrc) begin
            w_word = r_wdev;
        end else if (r_state == LRU_HELD) begin
            w_word = r_hreg;
        end
    end

    load_extender u_ext (
        .i_word (w_word),
        .i_ctrl (r_wctrl),
        .i_lane (r_wlane),
        .o_data (w_ext)
    );

    assign bus.oValid = r_wv;
    assign bus.oRData = r_wv ? w_ext : 32'd0;
endmodule

// File: tb/tb_load_return_unit.sv
// Bench for load_return_unit: directed scenarios with literal results, then random traffic
// compared every cycle against a transaction-level model of the load result.
`timescale 1ns/1ps
module tb_load_return_unit;
    import load_return_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_return_unit_if bus();

    load_return_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef LRU_DEV_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Model of the W-stage slot: the load in flight and, once known, the word it returns.
    logic        m_wv    = 1'b0;
    logic        m_known = 1'b0;
    logic [3:0]  m_ctrl  = 4'd0;
    logic [1:0]  m_lane  = 2'd0;
    logic [31:0] m_word  = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [3:0] c,
                                            input logic [1:0] lane);
        logic [31:0] b, h;
        b = (w >> (int'(lane) * 8)) & 32'h0000_00FF;
        h = (w >> (int'(lane[1]) * 16)) & 32'h0000_FFFF;
        case (c)
            DM_LB:   return b[7]  ? (b | 32'hFFFF_FF00) : b;
            DM_LBU:  return b;
            DM_LH:   return h[15] ? (h | 32'hFFFF_0000) : h;
            DM_LHU:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_decode(input logic [31:0] a, input logic [3:0] c, input logic v,
                                input logic intr, output logic exc, output logic dmre,
                                output logic devre);
        logic ld, dm, tmr, bad;
        ld  = v && !intr && (c == DM_LW || c == DM_LH || c == DM_LHU || c == DM_LB || c == DM_LBU);
        dm  = a < 32'h3000;
        tmr = (a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C);
        bad = !(dm || tmr) ||
              (c == DM_LW && a[1:0] != 2'b00) ||
              ((c == DM_LH || c == DM_LHU) && a[0]) ||
              (tmr && c != DM_LW && !SUBWORD);
        exc   = ld && bad;
        dmre  = ld && !bad && dm;
        devre = ld && !bad && tmr;
    endtask

    task automatic settle_check();
        logic e, d, v;
        logic [31:0] exp_rd;
        #3;
        model_decode(bus.iAddr, bus.ictrl, bus.iValid, bus.INT, e, d, v);
        check("exc", 32'(bus.oEXC), 32'(e));
        check("dm_re", 32'(bus.oDM_RE), 32'(d));
        check("dev_re", 32'(bus.oDEV_RE), 32'(v));
        exp_rd = m_wv ? ref_ext(m_known ? m_word : bus.iDM_RD, m_ctrl, m_lane) : 32'd0;
        check("valid", 32'(bus.oValid), 32'(m_wv));
        check("rdata", bus.oRData, exp_rd);
    endtask

    task automatic advance();
        logic e, d, v;
        if (reset) begin
            m_wv = 1'b0;
        end else if (bus.iFlush) begin
            m_wv = 1'b0;
        end else if (bus.iStall) begin
            if (m_wv && !m_known) begin
                m_word  = bus.iDM_RD;
                m_known = 1'b1;
            end
        end else begin
            model_decode(bus.iAddr, bus.ictrl, bus.iValid, bus.INT, e, d, v);
            m_wv    = d | v;
            m_ctrl  = bus.ictrl;
            m_lane  = bus.iAddr[1:0];
            m_known = v;
            m_word  = bus.iDEV_RD;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [3:0] c, input logic [31:0] a);
        bus.iValid = 1'b1;
        bus.ictrl  = c;
        bus.iAddr  = a;
    endtask

    task automatic idle();
        bus.iValid = 1'b0;
        bus.ictrl  = DM_NONE;
        bus.iAddr  = 32'd0;
    endtask

    logic [31:0] t4_addr [3];
    logic [3:0]  t4_ctrl [3];

    initial begin
        reset       = 1'b1;
        bus.INT     = 1'b0;
        bus.iStall  = 1'b0;
        bus.iFlush  = 1'b0;
        bus.iDM_RD  = 32'd0;
        bus.iDEV_RD = 32'd0;
        idle();
        @(posedge clk);
        #1;
        settle_check();
        check("rst_valid", 32'(bus.oValid), 32'd0);
        check("rst_rdata", bus.oRData, 32'd0);
        advance();
        reset = 1'b0;

        // LB / LBU from DM, lane 3
        ld(DM_LB, 32'h0000_0013);
        settle_check();
        check("t1_dm_re", 32'(bus.oDM_RE), 32'd1);
        check("t1_exc", 32'(bus.oEXC), 32'd0);
        advance();
        idle();
        bus.iDM_RD = 32'h80FF_7F01;
        settle_check();
        check("t1_lb_valid", 32'(bus.oValid), 32'd1);
        check("t1_lb", bus.oRData, 32'hFFFF_FF80);
        advance();
        ld(DM_LBU, 32'h0000_0013);
        settle_check();
        advance();
        idle();
        settle_check();
        check("t1_lbu", bus.oRData, 32'h0000_0080);
        advance();

        // LH held across a 3-cycle stall while DM data moves on
        ld(DM_LH, 32'h0000_0102);
        settle_check();
        advance();
        idle();
        bus.iDM_RD = 32'h8001_1234;
        bus.iStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) bus.iDM_RD = 32'hDEAD_BEEF;
            if (i == 3) bus.iStall = 1'b0;
            settle_check();
            check("t2_lh_hold", bus.oRData, 32'hFFFF_8001);
            advance();
        end

        // timer LW, and the first byte past timer 0's readable window
        ld(DM_LW, 32'h0000_7F14);
        bus.iDEV_RD = 32'h0000_00AB;
        settle_check();
        check("t3_dev_re", 32'(bus.oDEV_RE), 32'd1);
        advance();
        idle();
        bus.iDEV_RD = 32'h0000_0055;
        settle_check();
        check("t3_lw_dev", bus.oRData, 32'h0000_00AB);
        advance();
        ld(DM_LW, 32'h0000_7F0C);
        settle_check();
        check("t3_gap_exc", 32'(bus.oEXC), 32'd1);
        check("t3_gap_re", 32'(bus.oDEV_RE), 32'd0);
        advance();
        idle();
        settle_check();
        advance();

        // misaligned and miss addresses, then the same with INT
        t4_addr[0] = 32'h0000_0002; t4_ctrl[0] = DM_LW;
        t4_addr[1] = 32'h0000_0001; t4_ctrl[1] = DM_LH;
        t4_addr[2] = 32'h0000_4000; t4_ctrl[2] = DM_LW;
        for (int i = 0; i < 3; i++) begin
            ld(t4_ctrl[i], t4_addr[i]);
            settle_check();
            check("t4_exc", 32'(bus.oEXC), 32'd1);
            advance();
            idle();
            settle_check();
            check("t4_no_valid", 32'(bus.oValid), 32'd0);
            advance();
            ld(t4_ctrl[i], t4_addr[i]);
            bus.INT = 1'b1;
            settle_check();
            check("t4_int_exc", 32'(bus.oEXC), 32'd0);
            advance();
            bus.INT = 1'b0;
            idle();
        end

        // byte read from timer 0
        ld(DM_LB, 32'h0000_7F00);
        bus.iDEV_RD = 32'h1234_5685;
        settle_check();
        check("t5_exc", 32'(bus.oEXC), SUBWORD ? 32'd0 : 32'd1);
        advance();
        idle();
        bus.iDEV_RD = 32'h0;
        settle_check();
        check("t5_rdata", bus.oRData, SUBWORD ? 32'hFFFF_FF85 : 32'd0);
        advance();

        // flush+stall while HELD, then reset while FRESH
        ld(DM_LW, 32'h0000_0100);
        settle_check();
        advance();
        idle();
        bus.iDM_RD = 32'h1111_2222;
        bus.iStall = 1'b1;
        settle_check();
        advance();
        bus.iFlush = 1'b1;
        settle_check();
        check("t6_held", bus.oRData, 32'h1111_2222);
        advance();
        bus.iFlush = 1'b0;
        bus.iStall = 1'b0;
        settle_check();
        check("t6_flush_valid", 32'(bus.oValid), 32'd0);
        check("t6_flush_rdata", bus.oRData, 32'd0);
        advance();
        ld(DM_LW, 32'h0000_0200);
        settle_check();
        advance();
        idle();
        bus.iDM_RD = 32'hCAFE_F00D;
        reset = 1'b1;
        settle_check();
        advance();
        reset = 1'b0;
        settle_check();
        check("t6_rst_valid", 32'(bus.oValid), 32'd0);
        check("t6_rst_rdata", bus.oRData, 32'd0);
        advance();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    bus.iAddr = 32'($urandom_range(0, 32'h2FFF));
                2:       bus.iAddr = 32'h7F00 + 32'($urandom_range(0, 15));
                3:       bus.iAddr = 32'h7F10 + 32'($urandom_range(0, 15));
                4:       bus.iAddr = 32'h2FF8 + 32'($urandom_range(0, 15));
                default: bus.iAddr = $urandom();
            endcase
            bus.ictrl   = 4'($urandom_range(0, 9));
            bus.iValid  = $urandom_range(0, 3) != 0;
            bus.INT     = $urandom_range(0, 15) == 0;
            bus.iStall  = $urandom_range(0, 3) == 0;
            bus.iFlush  = $urandom_range(0, 11) == 0;
            reset       = $urandom_range(0, 63) == 0;
            bus.iDM_RD  = $urandom();
            bus.iDEV_RD = $urandom();
            settle_check();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
